// File: rtl/vga_text_pkg.sv
// Shared constants and types for the 80x30 text-mode video path.
// Geometry, RAM widths, arbiter state encoding and the character-cell address helper.
package vga_text_pkg;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int AW      = 12;
    localparam int DW      = 7;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CELLS   = COLS * ROWS;

    localparam logic [AW-1:0] COLS_V  = AW'(COLS);
    localparam logic [AW-1:0] CELLS_V = AW'(CELLS);

    typedef enum logic {
        DISP  = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    // row*COLS + col as a constant shift-add: one adder per set bit of COLS.
    function automatic logic [AW-1:0] cell_addr(input logic [AW-1:0] row,
                                                input logic [AW-1:0] col);
        logic [AW-1:0] acc;
        acc = col;
        for (int i = 0; i < AW; i++) begin
            if (COLS_V[i]) begin
                acc = acc + (row << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Generic synchronous FIFO with first-word fall-through head and occupancy count.
// Push is refused when full and pop when empty, both judged on the registered count.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port character RAM between video reads and buffered writes.
// Video owns the port during active display; queued writes drain only while blanking.
module vram_arbiter
    import vga_text_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          video_on,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          fifo_full,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] char_code,
    output logic          char_valid,
    output logic [2:0]    font_col,
    output logic [3:0]    font_row
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int X_SH  = $clog2(GLYPH_W);
    localparam int Y_SH  = $clog2(GLYPH_H);

    arb_state_t    state_q;
    arb_state_t    state_d;
    wr_entry_t     head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          addr_ok;
    logic [AW-1:0] vid_addr;
    logic          vo_d1;
    logic          vo_d2;
    logic [2:0]    col_d1;
    logic [2:0]    col_d2;
    logic [3:0]    row_d1;
    logic [3:0]    row_d2;

    assign vid_addr  = cell_addr(AW'(pixel_y[9:Y_SH]), AW'(pixel_x[9:X_SH]));
    assign addr_ok   = (wr_addr < CELLS_V);
    assign push      = wr_req && addr_ok && !full;
    assign fifo_full = (count == CW'(FIFO_DEPTH));

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AW + DW)
    ) u_wr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({wr_addr, wr_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Grant follows the sampled video_on; a pop only happens on a cycle granted to the writer.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            DISP:    if (!video_on) state_d = DRAIN;
            DRAIN:   if (video_on)  state_d = DISP;
            default: state_d = DISP;
        endcase
        if (state_d == DRAIN && !empty) begin
            pop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DISP;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ack  <= push;
            wr_err  <= wr_req && !addr_ok;
            if (state_d == DISP) begin
                ram_addr <= vid_addr;
                ram_we   <= 1'b0;
            end else if (pop) begin
                ram_addr  <= head.addr;
                ram_wdata <= head.data;
                ram_we    <= 1'b1;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

    // Two stages match the address register plus the RAM's own read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vo_d1  <= 1'b0;
            vo_d2  <= 1'b0;
            col_d1 <= '0;
            col_d2 <= '0;
            row_d1 <= '0;
            row_d2 <= '0;
        end else begin
            vo_d1  <= video_on;
            vo_d2  <= vo_d1;
            col_d1 <= pixel_x[2:0];
            col_d2 <= col_d1;
            row_d1 <= pixel_y[3:0];
            row_d2 <= row_d1;
        end
    end

    assign char_valid = vo_d2;
    assign font_col   = col_d2;
    assign font_row   = row_d2;
    assign char_code  = vo_d2 ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios then randomized traffic,
// compared every cycle against a queue-based reference model and a behavioural RAM.
module tb_vram_arbiter;
    import vga_text_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          video_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_err;
    logic          fifo_full;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] char_code;
    logic          char_valid;
    logic [2:0]    font_col;
    logic [3:0]    font_row;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int qa[$];
    int qd[$];
    int model_mem [4096];
    int exp_addr, exp_we, exp_wdata, exp_ack, exp_err, exp_full;
    int exp_valid, exp_char, exp_col, exp_row;
    int prev_vo, prev_vaddr, prev_col, prev_row;
    int pend_we, pend_addr, pend_data;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .fifo_full  (fifo_full),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .char_code  (char_code),
        .char_valid (char_valid),
        .font_col   (font_col),
        .font_row   (font_row)
    );

    // Synchronous single-port RAM, read-before-write, one cycle of read latency.
    logic [DW-1:0] vram [4096];
    initial begin
        ram_rdata = '0;
        for (int i = 0; i < 4096; i++) vram[i] = DW'((i * 37 + 11) % 128);
        forever begin
            @(posedge clk);
            ram_rdata <= vram[ram_addr];
            if (ram_we) vram[ram_addr] = ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        chk("ram_addr",   ram_addr,   exp_addr);
        chk("ram_we",     ram_we,     exp_we);
        chk("ram_wdata",  ram_wdata,  exp_wdata);
        chk("wr_ack",     wr_ack,     exp_ack);
        chk("wr_err",     wr_err,     exp_err);
        chk("fifo_full",  fifo_full,  exp_full);
        chk("char_valid", char_valid, exp_valid);
        chk("char_code",  char_code,  exp_char);
        chk("font_col",   font_col,   exp_col);
        chk("font_row",   font_row,   exp_row);
    endtask

    task automatic modelReset();
        qa.delete();
        qd.delete();
        exp_addr = 0; exp_we = 0; exp_wdata = 0; exp_ack = 0; exp_err = 0; exp_full = 0;
        exp_valid = 0; exp_char = 0; exp_col = 0; exp_row = 0;
        prev_vo = 0; prev_vaddr = 0; prev_col = 0; prev_row = 0;
        pend_we = 0;
    endtask

    // One clock edge of the arbiter seen as: a pending-write queue, a video address, a 2-cycle view.
    task automatic modelEdge(input int vo, input int x, input int y,
                             input int req, input int a, input int d);
        int vaddr;
        int size_before;
        if (pend_we != 0) model_mem[pend_addr] = pend_data;
        pend_we   = 0;
        exp_valid = prev_vo;
        exp_char  = (prev_vo != 0) ? model_mem[prev_vaddr] : 0;
        exp_col   = prev_col;
        exp_row   = prev_row;
        vaddr       = ((y / GLYPH_H) * COLS + (x / GLYPH_W)) % 4096;
        size_before = qa.size();
        exp_ack = (req != 0 && a < CELLS && size_before < 4) ? 1 : 0;
        exp_err = (req != 0 && a >= CELLS) ? 1 : 0;
        if (vo != 0) begin
            exp_addr = vaddr;
            exp_we   = 0;
        end else if (size_before > 0) begin
            exp_addr  = qa.pop_front();
            exp_wdata = qd.pop_front();
            exp_we    = 1;
            pend_we   = 1;
            pend_addr = exp_addr;
            pend_data = exp_wdata;
        end else begin
            exp_we = 0;
        end
        if (exp_ack != 0) begin
            qa.push_back(a);
            qd.push_back(d);
        end
        exp_full   = (qa.size() == 4) ? 1 : 0;
        prev_vo    = vo;
        prev_vaddr = vaddr;
        prev_col   = x % GLYPH_W;
        prev_row   = y % GLYPH_H;
    endtask

    task automatic applyStimulus(input int vo, input int x, input int y,
                                 input int req, input int a, input int d);
        video_on = 1'(vo);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        wr_req   = 1'(req);
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        @(posedge clk);
        #1;
        modelEdge(vo, x, y, req, a, d);
        checkOutput();
    endtask

    // Reset asserted between edges so its asynchronous effect is visible before the next edge.
    task automatic doReset();
        #2;
        rst    = 1'b1;
        wr_req = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;
    endtask

    initial begin
        int vo;
        int req;
        int a;
        for (int i = 0; i < 4096; i++) model_mem[i] = (i * 37 + 11) % 128;
        rst = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        modelReset();
        #3;
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;

        $display("[TB] idle blanking after reset");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] store 'A' at the last cell, then read it at the bottom-right pixel");
        applyStimulus(0, 0, 0, 1, 2399, 'h41);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 639, 479, 0, 0, 0);
        applyStimulus(1, 639, 479, 0, 0, 0);
        applyStimulus(1, 639, 479, 0, 0, 0);

        $display("[TB] deferred write during active video");
        applyStimulus(1, 100, 100, 1, 5, 'h41);
        applyStimulus(1, 108, 100, 0, 0, 0);
        applyStimulus(1, 116, 100, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 40, 0, 0, 0, 0);
        applyStimulus(1, 41, 0, 0, 0, 0);
        applyStimulus(1, 42, 0, 0, 0, 0);

        $display("[TB] backpressure with five requests");
        for (int k = 0; k < 5; k++) applyStimulus(1, k * 8, 16, 1, 100 + k, 'h30 + k);
        applyStimulus(0, 0, 0, 1, 104, 'h34);
        applyStimulus(0, 0, 0, 1, 104, 'h34);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] out-of-range addresses");
        applyStimulus(1, 0, 0, 1, 2400, 1);
        applyStimulus(1, 0, 0, 1, 4095, 2);
        applyStimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] push and pop in the same cycle");
        applyStimulus(1, 0, 0, 1, 200, 'h11);
        applyStimulus(0, 0, 0, 1, 201, 'h12);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset in the middle of a drain");
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 1, 300 + k, 'h50 + k);
        applyStimulus(0, 0, 0, 0, 0, 0);
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        vo = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) vo = 1 - vo;
            req = int'($urandom_range(1));
            a   = ($urandom_range(7) == 0) ? int'($urandom_range(4095, 2400))
                                           : int'($urandom_range(2399));
            applyStimulus(vo, int'($urandom_range(639)), int'($urandom_range(479)),
                          req, a, int'($urandom_range(127)));
            if (i == 200) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
